fire_control: RTL and testbench

FIRE_CONTROL -- requirements
Module: fire_control

---
 rtl/weapons_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 33 +++
 rtl/fire_control.sv | 182 ++++++++++++++++++
 tb/tb_fire_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weapons_pkg.sv
// Shared constants and state encoding for the fire-control block.
package weapons_pkg;

  localparam int AMMO_W   = 9;
  localparam int MAX_AMMO = 500;

  localparam logic [3:0] ATTACK_MODE = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FIRE     = 2'b01,
    ST_COOLDOWN = 2'b10,
    ST_RELOAD   = 2'b11
  } fc_state_e;

  // A timer loaded with N-1 reports done on its N-th cycle.
  function automatic logic [3:0] timer_preset(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 4'd0);

endmodule

// File: rtl/fire_control.sv
// Weapon fire-control sequencer: single/auto/burst fire with cooldown,
// illegal-fire detection and clamped reload, all outputs registered.
module fire_control #(
  parameter int AMMO_W        = weapons_pkg::AMMO_W,
  parameter int COOLDOWN      = 3,
  parameter int BURST_LEN     = 3,
  parameter int RELOAD_CYCLES = 2,
  parameter int MAX_AMMO      = weapons_pkg::MAX_AMMO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode_selector,
  input  logic              trigger,
  input  logic              burst_en,
  input  logic [AMMO_W-1:0] ammo_level,
  input  logic [AMMO_W-1:0] fire_rate,
  input  logic              reload_req,
  input  logic [AMMO_W-1:0] reload_amount,
  output logic              fire,
  output logic [AMMO_W-1:0] rate,
  output logic              load,
  output logic [AMMO_W-1:0] ammo_in,
  output logic              error,
  output logic              busy,
  output logic [1:0]        state
);
  import weapons_pkg::*;

  localparam logic [3:0]        CD_PRESET = timer_preset(COOLDOWN);
  localparam logic [3:0]        RL_PRESET = timer_preset(RELOAD_CYCLES);
  localparam logic [3:0]        BURST_MAX = 4'(BURST_LEN);
  localparam logic [AMMO_W-1:0] MAX_V     = AMMO_W'(MAX_AMMO);

  fc_state_e         state_q, state_d;
  logic [3:0]        shot_cnt_q, shot_cnt_d;
  logic              burst_q, burst_d;
  logic [AMMO_W-1:0] rate_q, rate_d;
  logic [AMMO_W-1:0] ammo_in_q, ammo_in_d;
  logic              fire_q, fire_d;
  logic              load_q, load_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;

  logic       attack;
  logic       ok;
  logic       enter_fire;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_en;
  logic       tmr_done;

  assign attack = (mode_selector == ATTACK_MODE);
  assign ok     = attack && (fire_rate != '0) && (ammo_level >= fire_rate);
  assign tmr_en = (state_q == ST_COOLDOWN) || (state_q == ST_RELOAD);

  cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    shot_cnt_d = shot_cnt_q;
    burst_d    = burst_q;
    rate_d     = rate_q;
    ammo_in_d  = ammo_in_q;
    error_d    = 1'b0;
    enter_fire = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (reload_req) begin
          state_d   = ST_RELOAD;
          ammo_in_d = (reload_amount > MAX_V) ? MAX_V : reload_amount;
          tmr_load  = 1'b1;
          tmr_val   = RL_PRESET;
        end else if (trigger) begin
          if (ok) begin
            enter_fire = 1'b1;
            burst_d    = burst_en;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_FIRE: begin
        if (!attack) begin
          state_d    = ST_IDLE;
          shot_cnt_d = 4'd0;
        end else begin
          state_d  = ST_COOLDOWN;
          tmr_load = 1'b1;
          tmr_val  = CD_PRESET;
        end
      end

      ST_COOLDOWN: begin
        // Mode abort wins over the repeat decision and is silent.
        if (!attack) begin
          state_d    = ST_IDLE;
          shot_cnt_d = 4'd0;
        end else if (tmr_done) begin
          if (burst_q) begin
            if ((shot_cnt_q < BURST_MAX) && ok) begin
              enter_fire = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              shot_cnt_d = 4'd0;
              error_d    = (shot_cnt_q < BURST_MAX);
            end
          end else begin
            if (trigger && ok) begin
              enter_fire = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              shot_cnt_d = 4'd0;
              error_d    = trigger;
            end
          end
        end
      end

      ST_RELOAD: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_fire) begin
      state_d    = ST_FIRE;
      rate_d     = fire_rate;
      shot_cnt_d = (shot_cnt_q == 4'hF) ? shot_cnt_q : shot_cnt_q + 4'd1;
    end

    fire_d = (state_d == ST_FIRE);
    load_d = (state_d == ST_RELOAD);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shot_cnt_q <= 4'd0;
      burst_q    <= 1'b0;
      rate_q     <= '0;
      ammo_in_q  <= '0;
      fire_q     <= 1'b0;
      load_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shot_cnt_q <= shot_cnt_d;
      burst_q    <= burst_d;
      rate_q     <= rate_d;
      ammo_in_q  <= ammo_in_d;
      fire_q     <= fire_d;
      load_q     <= load_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  assign fire    = fire_q;
  assign rate    = rate_q;
  assign load    = load_q;
  assign ammo_in = ammo_in_q;
  assign error   = error_q;
  assign busy    = busy_q;
  assign state   = state_q;

endmodule

// File: tb/tb_fire_control.sv
// Directed bench for fire_control: auto, burst, illegal fire, reload clamp,
// mode abort, out-of-ammo repeat and asynchronous reset.
module tb_fire_control;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic [3:0]   mode_selector;
  logic         trigger;
  logic         burst_en;
  logic [W-1:0] ammo_level;
  logic [W-1:0] fire_rate;
  logic         reload_req;
  logic [W-1:0] reload_amount;
  logic         fire;
  logic [W-1:0] rate;
  logic         load;
  logic [W-1:0] ammo_in;
  logic         error;
  logic         busy;
  logic [1:0]   state;

  int n_checks = 0;
  int n_pass   = 0;
  int fires;
  int errs;

  int exp_fire  [7] = '{1, 0, 0, 0, 1, 0, 0};
  int exp_state [7] = '{1, 2, 2, 2, 1, 2, 2};

  fire_control #(.AMMO_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode_selector (mode_selector),
    .trigger       (trigger),
    .burst_en      (burst_en),
    .ammo_level    (ammo_level),
    .fire_rate     (fire_rate),
    .reload_req    (reload_req),
    .reload_amount (reload_amount),
    .fire          (fire),
    .rate          (rate),
    .load          (load),
    .ammo_in       (ammo_in),
    .error         (error),
    .busy          (busy),
    .state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
      $display("ok   %s: %0d (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_fire"}, fire, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rate"}, rate, 0);
    check({tag, "_ammo_in"}, ammo_in, 0);
  endtask

  initial begin
    rst           = 1'b0;
    mode_selector = 4'b0000;
    trigger       = 1'b0;
    burst_en      = 1'b0;
    ammo_level    = '0;
    fire_rate     = '0;
    reload_req    = 1'b0;
    reload_amount = '0;

    #2;
    check_all_zero("reset");

    // Auto fire: trigger held, one shot every 4 cycles
    @(negedge clk);
    @(negedge clk);
    rst           = 1'b1;
    mode_selector = 4'b0010;
    ammo_level    = 10'd500;
    fire_rate     = 10'd5;
    trigger       = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("auto_fire_%0d", i), fire, exp_fire[i]);
      check($sformatf("auto_state_%0d", i), state, exp_state[i]);
      if (i == 0) check("auto_rate", rate, 5);
    end

    // Asynchronous reset at 100 ns, mid-cooldown
    @(negedge clk);
    check("pre_reset_state", state, 2);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    trigger = 1'b0;

    // Burst with a one-cycle trigger
    @(negedge clk);
    rst      = 1'b1;
    burst_en = 1'b1;
    trigger  = 1'b1;
    @(negedge clk);
    check("burst_first_fire", fire, 1);
    trigger  = 1'b0;
    burst_en = 1'b0;
    fires = 1;
    errs  = 0;
    repeat (15) begin
      @(negedge clk);
      fires += int'(fire);
      errs  += int'(error);
    end
    check("burst_fire_count", fires, 3);
    check("burst_error_count", errs, 0);
    check("burst_end_state", state, 0);
    check("burst_end_busy", busy, 0);

    // Illegal fire: not enough ammo
    ammo_level = 10'd3;
    trigger    = 1'b1;
    @(negedge clk);
    check("low_ammo_error", error, 1);
    check("low_ammo_fire", fire, 0);
    check("low_ammo_state", state, 0);
    trigger = 1'b0;
    @(negedge clk);
    check("low_ammo_error_clear", error, 0);

    // Illegal fire: zero rate
    ammo_level = 10'd500;
    fire_rate  = 10'd0;
    trigger    = 1'b1;
    @(negedge clk);
    check("zero_rate_error", error, 1);
    check("zero_rate_state", state, 0);
    trigger   = 1'b0;
    fire_rate = 10'd5;
    @(negedge clk);

    // Reload has priority over trigger; amount clamped to 500
    reload_req    = 1'b1;
    trigger       = 1'b1;
    reload_amount = 10'd600;
    @(negedge clk);
    check("reload_state", state, 3);
    check("reload_load_1", load, 1);
    check("reload_ammo_in", ammo_in, 500);
    check("reload_fire_1", fire, 0);
    check("reload_busy", busy, 1);
    reload_req = 1'b0;
    @(negedge clk);
    check("reload_load_2", load, 1);
    check("reload_state_2", state, 3);
    check("reload_no_error", error, 0);
    check("reload_fire_2", fire, 0);
    @(negedge clk);
    check("reload_done_load", load, 0);
    check("reload_done_state", state, 0);
    check("reload_done_fire", fire, 0);
    trigger = 1'b0;
    @(negedge clk);
    check("post_reload_fire", fire, 0);

    // Reload below the clamp passes through
    reload_amount = 10'd123;
    reload_req    = 1'b1;
    @(negedge clk);
    check("reload_small_ammo_in", ammo_in, 123);
    reload_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reload_small_end_state", state, 0);

    // Mode change mid-burst aborts silently
    burst_en = 1'b1;
    trigger  = 1'b1;
    @(negedge clk);
    check("abort_first_fire", fire, 1);
    trigger = 1'b0;
    @(negedge clk);
    check("abort_in_cooldown", state, 2);
    mode_selector = 4'b0100;
    @(negedge clk);
    check("abort_state", state, 0);
    check("abort_error", error, 0);
    check("abort_busy", busy, 0);
    fires = 0;
    errs  = 0;
    repeat (8) begin
      @(negedge clk);
      fires += int'(fire);
      errs  += int'(error);
    end
    check("abort_no_more_fire", fires, 0);
    check("abort_no_error", errs, 0);
    mode_selector = 4'b0010;
    burst_en      = 1'b0;

    // Auto fire runs dry at the repeat decision; reload_req in cooldown ignored
    trigger = 1'b1;
    @(negedge clk);
    check("dry_first_fire", fire, 1);
    ammo_level = 10'd4;
    @(negedge clk);
    check("dry_cooldown_1", state, 2);
    reload_req = 1'b1;
    @(negedge clk);
    check("dry_reload_ignored_state", state, 2);
    check("dry_reload_ignored_load", load, 0);
    reload_req = 1'b0;
    @(negedge clk);
    check("dry_cooldown_3", state, 2);
    @(negedge clk);
    check("dry_error", error, 1);
    check("dry_state", state, 0);
    check("dry_fire", fire, 0);
    trigger = 1'b0;
    @(negedge clk);
    check("dry_error_clear", error, 0);
    check("dry_idle", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
